ara_pe_req_dispatcher: RTL and testbench

// - Decoupled issue stage between the sequencer and the NrPEs processing elements (lanes, load, store, slide, mask).
// - Buffers issued requests and presents the head entry to every targeted PE.
// - Tracks per-PE acceptance, so PEs handshake independently; no simultaneous all-PE ready is needed.
// - Retires the head entry once every targeted PE has accepted it.

---
 rtl/ara_pe_req_dispatcher_pkg.sv | 49 ++++
 rtl/ara_pe_req_dispatcher_if.sv | 29 ++
 rtl/ara_pe_req_dispatcher_fifo.sv | 63 ++++++
 rtl/ara_pe_req_dispatcher.sv | 110 +++++++++++
 tb/tb_ara_pe_req_dispatcher.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ara_pe_req_dispatcher_pkg.sv
// Shared types for the PE request dispatcher: PE target vector, request
// payload and the helper that maps a functional unit to its target PEs.
package ara_pe_req_dispatcher_pkg;

  localparam int unsigned NrLanes     = 1;
  localparam int unsigned OffsetLoad  = NrLanes;
  localparam int unsigned OffsetStore = NrLanes + 1;
  localparam int unsigned OffsetSlide = NrLanes + 2;
  localparam int unsigned OffsetMask  = NrLanes + 3;

  // One bit per PE: lanes first, then load, store, slide, mask.
  typedef logic [NrLanes+3:0] pe_target_t;

  typedef enum logic [2:0] {
    VFU_None      = 3'd0,
    VFU_Alu       = 3'd1,
    VFU_MFpu      = 3'd2,
    VFU_SlideUnit = 3'd3,
    VFU_MaskUnit  = 3'd4,
    VFU_LoadUnit  = 3'd5,
    VFU_StoreUnit = 3'd6
  } vfu_e;

  typedef struct packed {
    logic [3:0]  id;
    vfu_e        vfu;
    logic        vm;
    logic [4:0]  vd;
    logic [15:0] scalar_op;
  } pe_req_t;

  // PEs that must see a request for the given unit; a masked op (vm=0)
  // additionally needs the mask unit.
  function automatic pe_target_t vfu_target(input vfu_e vfu, input logic vm);
    pe_target_t t;
    t = '0;
    case (vfu)
      VFU_Alu, VFU_MFpu: t[NrLanes-1:0] = '1;
      VFU_LoadUnit:      t[OffsetLoad]  = 1'b1;
      VFU_StoreUnit:     t[OffsetStore] = 1'b1;
      VFU_SlideUnit:     t[OffsetSlide] = 1'b1;
      VFU_MaskUnit:      t[OffsetMask]  = 1'b1;
      default:           t = '0;
    endcase
    if (!vm) t[OffsetMask] = 1'b1;
    return t;
  endfunction

endpackage

// File: rtl/ara_pe_req_dispatcher_if.sv
// Sequencer-to-dispatcher request channel plus the per-PE broadcast channel.
interface ara_pe_req_dispatcher_if
  import ara_pe_req_dispatcher_pkg::*;
#(
  parameter int unsigned NrPEs = 5,
  parameter type         req_t = pe_req_t
) ();

  req_t             req;
  logic [NrPEs-1:0] target;
  logic             req_valid;
  logic             req_ready;
  req_t             pe_req;
  logic [NrPEs-1:0] pe_req_valid;
  logic [NrPEs-1:0] pe_req_ready;

  // Environment side: sequencer issuing requests and PEs accepting them.
  modport master (
    output req, target, req_valid, pe_req_ready,
    input  req_ready, pe_req, pe_req_valid
  );

  // Dispatcher side.
  modport slave (
    input  req, target, req_valid, pe_req_ready,
    output req_ready, pe_req, pe_req_valid
  );

endinterface

// File: rtl/ara_pe_req_dispatcher_fifo.sv
// Request buffer without fall-through; flush has priority over push and pop,
// push when full and pop when empty are ignored.
module ara_pe_req_dispatcher_fifo #(
  parameter int unsigned Depth     = 2,
  parameter int unsigned DataWidth = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [DataWidth-1:0]         data_i,
  input  logic                         pop_i,
  output logic [DataWidth-1:0]         data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   usage_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [DataWidth-1:0] r_mem [Depth];
  logic [PtrW-1:0]      r_wr_ptr;
  logic [PtrW-1:0]      r_rd_ptr;
  logic [CntW-1:0]      r_cnt;
  logic                 w_push;
  logic                 w_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (r_cnt == CntW'(Depth));
  assign empty_o = (r_cnt == '0);
  assign usage_o = r_cnt;
  assign data_o  = r_mem[r_rd_ptr];
  assign w_push  = push_i && !full_o && !flush_i;
  assign w_pop   = pop_i && !empty_o && !flush_i;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CntW'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - CntW'(1);
    end
  end

  // Storage array; contents are only observed while the buffer is non-empty.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/ara_pe_req_dispatcher.sv
// Decoupled issue stage: buffers sequencer requests and broadcasts the head
// entry to its target PEs, each of which handshakes independently. The head
// retires once every targeted PE has accepted it.
// Optional build macro ARA_DISPATCH_STATS_EN enables the head-stall counter.
module ara_pe_req_dispatcher
  import ara_pe_req_dispatcher_pkg::*;
#(
  parameter int unsigned NrPEs = 5,
  parameter int unsigned Depth = 2,
  parameter type         req_t = pe_req_t
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  ara_pe_req_dispatcher_if.slave     bus,
  output logic [$clog2(Depth+1)-1:0] occupancy_o,
  output logic                       idle_o,
  output logic [31:0]                stall_cnt_o
);

  localparam int unsigned ReqW  = $bits(req_t);
  localparam int unsigned DataW = ReqW + NrPEs;
  localparam int unsigned CntW  = $clog2(Depth + 1);

  logic [DataW-1:0] w_push_data;
  logic [DataW-1:0] w_head_data;
  logic             w_full;
  logic             w_empty;
  logic             w_req_ready;
  logic             w_push;
  logic             w_done;
  logic [CntW-1:0]  w_usage;
  req_t             w_head_req;
  logic [NrPEs-1:0] w_head_tgt;
  logic [NrPEs-1:0] w_valid;
  logic [NrPEs-1:0] w_hs;
  logic [NrPEs-1:0] r_accepted;

  // Full is a registered-occupancy function; no pop bypass, and flush blocks intake.
  assign w_req_ready = !w_full && !flush_i;
  assign w_push      = bus.req_valid && w_req_ready;
  assign w_push_data = {bus.req, bus.target};

  ara_pe_req_dispatcher_fifo #(
    .Depth     (Depth),
    .DataWidth (DataW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (w_push),
    .data_i  (w_push_data),
    .pop_i   (w_done),
    .data_o  (w_head_data),
    .full_o  (w_full),
    .empty_o (w_empty),
    .usage_o (w_usage)
  );

  assign w_head_req = w_head_data[DataW-1:NrPEs];
  assign w_head_tgt = w_head_data[NrPEs-1:0];

  // Per-PE valid, handshakes and head retirement (zero target retires at once).
  always_comb begin
    w_valid = '0;
    if (!w_empty) w_valid = w_head_tgt & ~r_accepted;
    w_hs   = w_valid & bus.pe_req_ready;
    w_done = !w_empty && (((r_accepted | w_hs) & w_head_tgt) == w_head_tgt);
  end

  // Broadcast payload; an empty buffer presents an all-zero request.
  always_comb begin
    bus.pe_req = '0;
    if (!w_empty) bus.pe_req = w_head_req;
  end

  assign bus.pe_req_valid = w_valid;
  assign bus.req_ready    = w_req_ready;
  assign occupancy_o      = w_usage;
  assign idle_o           = (w_usage == '0);

  // Remember which PEs already took the head; fresh for every new head.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_accepted <= '0;
    end else if (flush_i || w_done) begin
      r_accepted <= '0;
    end else begin
      r_accepted <= r_accepted | w_hs;
    end
  end

`ifdef ARA_DISPATCH_STATS_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of cycles the head sits unretired; only reset clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (!w_empty && !w_done && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ara_pe_req_dispatcher.sv
// Directed bench for the PE request dispatcher (NrPEs=5, Depth=2).
module tb_ara_pe_req_dispatcher;
  import ara_pe_req_dispatcher_pkg::*;

  logic        clk_i;
  logic        rst_ni;
  logic        flush_i;
  logic [1:0]  occupancy_o;
  logic        idle_o;
  logic [31:0] stall_cnt_o;
  int          total;
  int          bad;

`ifdef ARA_DISPATCH_STATS_EN
  localparam logic [31:0] ExpStall = 32'd7;
`else
  localparam logic [31:0] ExpStall = 32'd0;
`endif

  ara_pe_req_dispatcher_if #(.NrPEs(5)) bus ();

  ara_pe_req_dispatcher #(
    .NrPEs (5),
    .Depth (2)
  ) u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .bus         (bus),
    .occupancy_o (occupancy_o),
    .idle_o      (idle_o),
    .stall_cnt_o (stall_cnt_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic pe_req_t mk_req(input logic [3:0] id);
    pe_req_t r;
    r           = '0;
    r.id        = id;
    r.vfu       = VFU_Alu;
    r.vm        = 1'b1;
    r.vd        = {1'b0, id};
    r.scalar_op = 16'hA000 | {12'h000, id};
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req          = '0;
    bus.target       = '0;
    bus.req_valid    = 1'b0;
    bus.pe_req_ready = '0;
    flush_i          = 1'b0;
  endtask

  task automatic drive_req(input logic [3:0] id, input logic [4:0] tgt);
    bus.req       = mk_req(id);
    bus.target    = tgt;
    bus.req_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle_inputs();
    #2;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", bus.req_ready); end
    total++; if (bus.pe_req_valid !== 5'b00000) begin bad++; $display("FAIL rst_valid got=%b exp=00000", bus.pe_req_valid); end
    total++; if (bus.pe_req !== pe_req_t'('0)) begin bad++; $display("FAIL rst_payload got=%h exp=0", bus.pe_req); end
    total++; if (occupancy_o !== 2'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", occupancy_o); end
    total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL rst_idle got=%b exp=1", idle_o); end
    total++; if (stall_cnt_o !== 32'd0) begin bad++; $display("FAIL rst_stall got=%0d exp=0", stall_cnt_o); end
    next_cycle();
    next_cycle();
    rst_ni = 1'b1;
    next_cycle();
  endtask

  task automatic test_vfu_target();
    total++; if (vfu_target(VFU_Alu, 1'b1) !== 5'b00001) begin bad++; $display("FAIL vfu_alu got=%b exp=00001", vfu_target(VFU_Alu, 1'b1)); end
    total++; if (vfu_target(VFU_LoadUnit, 1'b0) !== 5'b10010) begin bad++; $display("FAIL vfu_load_masked got=%b exp=10010", vfu_target(VFU_LoadUnit, 1'b0)); end
    total++; if (vfu_target(VFU_SlideUnit, 1'b1) !== 5'b01000) begin bad++; $display("FAIL vfu_slide got=%b exp=01000", vfu_target(VFU_SlideUnit, 1'b1)); end
  endtask

  task automatic test_stall_and_async_reset();
    drive_req(4'd1, 5'b00001);
    next_cycle();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 7; k++) next_cycle();
    @(negedge clk_i);
    total++; if (stall_cnt_o !== ExpStall) begin bad++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt_o, ExpStall); end
    total++; if (bus.pe_req_valid !== 5'b00001) begin bad++; $display("FAIL stall_valid got=%b exp=00001", bus.pe_req_valid); end
    rst_ni = 1'b0;
    #1;
    total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL arst_idle got=%b exp=1", idle_o); end
    total++; if (occupancy_o !== 2'd0) begin bad++; $display("FAIL arst_occ got=%0d exp=0", occupancy_o); end
    total++; if (bus.pe_req_valid !== 5'b00000) begin bad++; $display("FAIL arst_valid got=%b exp=00000", bus.pe_req_valid); end
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b exp=1", bus.req_ready); end
    total++; if (bus.pe_req !== pe_req_t'('0)) begin bad++; $display("FAIL arst_payload got=%h exp=0", bus.pe_req); end
    total++; if (stall_cnt_o !== 32'd0) begin bad++; $display("FAIL arst_stall got=%0d exp=0", stall_cnt_o); end
    next_cycle();
    rst_ni = 1'b1;
    next_cycle();
  endtask

  task automatic test_independent_accept();
    drive_req(4'd2, 5'b00011);
    @(negedge clk_i);
    total++; if (bus.pe_req_valid !== 5'b00000) begin bad++; $display("FAIL ia_no_fallthrough got=%b exp=00000", bus.pe_req_valid); end
    next_cycle();
    bus.req_valid = 1'b0; bus.pe_req_ready = 5'b00001;
    @(negedge clk_i);
    total++; if (bus.pe_req_valid !== 5'b00011) begin bad++; $display("FAIL ia_valid_t1 got=%b exp=00011", bus.pe_req_valid); end
    total++; if (bus.pe_req !== mk_req(4'd2)) begin bad++; $display("FAIL ia_payload got=%h exp=%h", bus.pe_req, mk_req(4'd2)); end
    next_cycle();
    bus.pe_req_ready = 5'b00000;
    @(negedge clk_i);
    total++; if (bus.pe_req_valid !== 5'b00010) begin bad++; $display("FAIL ia_valid_t2 got=%b exp=00010", bus.pe_req_valid); end
    next_cycle();
    bus.pe_req_ready = 5'b00010;
    @(negedge clk_i);
    total++; if (bus.pe_req_valid !== 5'b00010) begin bad++; $display("FAIL ia_valid_t3 got=%b exp=00010", bus.pe_req_valid); end
    total++; if (occupancy_o !== 2'd1) begin bad++; $display("FAIL ia_occ_t3 got=%0d exp=1", occupancy_o); end
    next_cycle();
    bus.pe_req_ready = 5'b00000;
    @(negedge clk_i);
    total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL ia_idle_t4 got=%b exp=1", idle_o); end
    total++; if (bus.pe_req_valid !== 5'b00000) begin bad++; $display("FAIL ia_valid_t4 got=%b exp=00000", bus.pe_req_valid); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    drive_req(4'd3, 5'b00001);
    @(negedge clk_i);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_c0 got=%b exp=1", bus.req_ready); end
    next_cycle();
    drive_req(4'd4, 5'b00100);
    @(negedge clk_i);
    total++; if (occupancy_o !== 2'd1) begin bad++; $display("FAIL b2b_occ_c1 got=%0d exp=1", occupancy_o); end
    next_cycle();
    drive_req(4'd5, 5'b01000);
    @(negedge clk_i);
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_c2 got=%b exp=0", bus.req_ready); end
    total++; if (occupancy_o !== 2'd2) begin bad++; $display("FAIL b2b_occ_c2 got=%0d exp=2", occupancy_o); end
    total++; if (bus.pe_req !== mk_req(4'd3)) begin bad++; $display("FAIL b2b_head_c2 got=%h exp=%h", bus.pe_req, mk_req(4'd3)); end
    next_cycle();
    bus.pe_req_ready = 5'b11111;
    @(negedge clk_i);
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL b2b_no_bypass got=%b exp=0", bus.req_ready); end
    total++; if (bus.pe_req_valid !== 5'b00001) begin bad++; $display("FAIL b2b_valid_c3 got=%b exp=00001", bus.pe_req_valid); end
    next_cycle();
    @(negedge clk_i);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_c4 got=%b exp=1", bus.req_ready); end
    total++; if (occupancy_o !== 2'd1) begin bad++; $display("FAIL b2b_occ_c4 got=%0d exp=1", occupancy_o); end
    total++; if (bus.pe_req !== mk_req(4'd4)) begin bad++; $display("FAIL b2b_head_c4 got=%h exp=%h", bus.pe_req, mk_req(4'd4)); end
    next_cycle();
    bus.req_valid = 1'b0;
    @(negedge clk_i);
    total++; if (bus.pe_req !== mk_req(4'd5)) begin bad++; $display("FAIL b2b_head_c5 got=%h exp=%h", bus.pe_req, mk_req(4'd5)); end
    total++; if (occupancy_o !== 2'd1) begin bad++; $display("FAIL b2b_occ_c5 got=%0d exp=1", occupancy_o); end
    total++; if (bus.pe_req_valid !== 5'b01000) begin bad++; $display("FAIL b2b_valid_c5 got=%b exp=01000", bus.pe_req_valid); end
    next_cycle();
    bus.pe_req_ready = 5'b00000;
    @(negedge clk_i);
    total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL b2b_idle_c6 got=%b exp=1", idle_o); end
    next_cycle();
  endtask

  task automatic test_independent_retire();
    drive_req(4'd6, 5'b10000);
    next_cycle();
    drive_req(4'd7, 5'b00001);
    bus.pe_req_ready = 5'b10000;
    @(negedge clk_i);
    total++; if (bus.pe_req_valid !== 5'b10000) begin bad++; $display("FAIL ir_valid_c1 got=%b exp=10000", bus.pe_req_valid); end
    total++; if (bus.pe_req !== mk_req(4'd6)) begin bad++; $display("FAIL ir_head_c1 got=%h exp=%h", bus.pe_req, mk_req(4'd6)); end
    next_cycle();
    bus.req_valid = 1'b0; bus.pe_req_ready = 5'b00000;
    @(negedge clk_i);
    total++; if (bus.pe_req !== mk_req(4'd7)) begin bad++; $display("FAIL ir_head_c2 got=%h exp=%h", bus.pe_req, mk_req(4'd7)); end
    total++; if (bus.pe_req_valid !== 5'b00001) begin bad++; $display("FAIL ir_valid_c2 got=%b exp=00001", bus.pe_req_valid); end
    total++; if (occupancy_o !== 2'd1) begin bad++; $display("FAIL ir_occ_c2 got=%0d exp=1", occupancy_o); end
    next_cycle();
    bus.pe_req_ready = 5'b00001;
    next_cycle();
    bus.pe_req_ready = 5'b00000;
    @(negedge clk_i);
    total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL ir_idle got=%b exp=1", idle_o); end
    next_cycle();
  endtask

  task automatic test_zero_target();
    drive_req(4'd8, 5'b00000);
    next_cycle();
    bus.req_valid = 1'b0;
    @(negedge clk_i);
    total++; if (bus.pe_req_valid !== 5'b00000) begin bad++; $display("FAIL zt_valid got=%b exp=00000", bus.pe_req_valid); end
    total++; if (occupancy_o !== 2'd1) begin bad++; $display("FAIL zt_occ_head got=%0d exp=1", occupancy_o); end
    next_cycle();
    @(negedge clk_i);
    total++; if (occupancy_o !== 2'd0) begin bad++; $display("FAIL zt_occ_after got=%0d exp=0", occupancy_o); end
    total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL zt_idle got=%b exp=1", idle_o); end
    next_cycle();
  endtask

  task automatic test_flush();
    drive_req(4'd9, 5'b00011);
    next_cycle();
    drive_req(4'd10, 5'b00001);
    bus.pe_req_ready = 5'b00001;
    @(negedge clk_i);
    total++; if (bus.pe_req_valid !== 5'b00011) begin bad++; $display("FAIL fl_valid_c1 got=%b exp=00011", bus.pe_req_valid); end
    next_cycle();
    drive_req(4'd11, 5'b00001);
    flush_i = 1'b1; bus.pe_req_ready = 5'b11111;
    @(negedge clk_i);
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL fl_ready_flush got=%b exp=0", bus.req_ready); end
    total++; if (occupancy_o !== 2'd2) begin bad++; $display("FAIL fl_occ_c2 got=%0d exp=2", occupancy_o); end
    total++; if (bus.pe_req_valid !== 5'b00010) begin bad++; $display("FAIL fl_valid_c2 got=%b exp=00010", bus.pe_req_valid); end
    next_cycle();
    flush_i = 1'b0; bus.pe_req_ready = 5'b00000;
    drive_req(4'd12, 5'b00001);
    @(negedge clk_i);
    total++; if (bus.pe_req_valid !== 5'b00000) begin bad++; $display("FAIL fl_valid_c3 got=%b exp=00000", bus.pe_req_valid); end
    total++; if (occupancy_o !== 2'd0) begin bad++; $display("FAIL fl_occ_c3 got=%0d exp=0", occupancy_o); end
    total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL fl_idle_c3 got=%b exp=1", idle_o); end
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL fl_ready_c3 got=%b exp=1", bus.req_ready); end
    next_cycle();
    bus.req_valid = 1'b0;
    bus.pe_req_ready = 5'b00001;
    @(negedge clk_i);
    total++; if (bus.pe_req_valid !== 5'b00001) begin bad++; $display("FAIL fl_retarget got=%b exp=00001", bus.pe_req_valid); end
    total++; if (bus.pe_req !== mk_req(4'd12)) begin bad++; $display("FAIL fl_head_c4 got=%h exp=%h", bus.pe_req, mk_req(4'd12)); end
    total++; if (occupancy_o !== 2'd1) begin bad++; $display("FAIL fl_occ_c4 got=%0d exp=1", occupancy_o); end
    next_cycle();
    bus.pe_req_ready = 5'b00000;
    @(negedge clk_i);
    total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL fl_idle_c5 got=%b exp=1", idle_o); end
    next_cycle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_vfu_target();
    test_stall_and_async_reset();
    test_independent_accept();
    test_back_to_back();
    test_independent_retire();
    test_zero_target();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
